// File: rtl/hwag_pkg.sv
// Shared types and helpers for the angle-generator output channels.
// Holds the angle geometry, channel state encoding and the arc test.
package hwag_pkg;

  localparam int ANGLE_WIDTH = 24;
  localparam int REV_TOP     = 3839;
  localparam int CYCLE_TOP   = 7679;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ON
  } ch_state_t;

  typedef logic [ANGLE_WIDTH-1:0] angle_t;

  // True when tgt lies in (prev, cur], wrapping through the cycle top.
  function automatic logic in_arc(
    input angle_t prev,
    input angle_t cur,
    input angle_t tgt
  );
    logic hit;
    hit = 1'b0;
    if (cur > prev)
      hit = (tgt > prev) && (tgt <= cur);
    else if (cur < prev)
      hit = (tgt > prev) || (tgt <= cur);
    return hit;
  endfunction

endpackage

// File: rtl/hwag_arc_cross.sv
// Combinational crossing detector: did the angle pass the target
// between the previous and the current sample.
module hwag_arc_cross
  import hwag_pkg::*;
(
  input  logic [ANGLE_WIDTH-1:0] prev,
  input  logic [ANGLE_WIDTH-1:0] cur,
  input  logic [ANGLE_WIDTH-1:0] target,
  output logic                   hit
);

  assign hit = in_arc(prev, cur, target);

endmodule

// File: rtl/hwag_ign_channel.sv
// One ignition/injection channel: fires out between two programmable
// 720-degree cycle angles, with double-buffered config and max-on guard.
module hwag_ign_channel #(
  parameter int ANGLE_WIDTH = 24,
  parameter int REV_TOP     = 3839,
  parameter int CYCLE_TOP   = 7679,
  parameter int TMR_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   hwag_start,
  input  logic [ANGLE_WIDTH-1:0] acnt,
  input  logic                   phase,
  input  logic [ANGLE_WIDTH-1:0] cfg_set,
  input  logic [ANGLE_WIDTH-1:0] cfg_reset,
  input  logic [TMR_WIDTH-1:0]   cfg_max_on,
  input  logic                   cfg_wr,
  input  logic                   ch_ena,
  output logic                   out,
  output logic                   busy,
  output logic                   tmo,
  output logic                   cfg_err
);
  import hwag_pkg::*;

  localparam logic [ANGLE_WIDTH-1:0] REV_LEN =
    ANGLE_WIDTH'(REV_TOP + 1);
  localparam logic [ANGLE_WIDTH-1:0] CYC_MAX =
    ANGLE_WIDTH'(CYCLE_TOP);

  ch_state_t state, state_n;

  logic [ANGLE_WIDTH-1:0] cyc;
  logic [ANGLE_WIDTH-1:0] prev_cyc;
  logic [ANGLE_WIDTH-1:0] sh_set;
  logic [ANGLE_WIDTH-1:0] sh_reset;
  logic [ANGLE_WIDTH-1:0] act_set;
  logic [ANGLE_WIDTH-1:0] act_reset;
  logic [TMR_WIDTH-1:0]   timer;

  logic pending;
  logic set_hit;
  logic reset_hit;
  logic lock;
  logic wrap;
  logic cfg_ok;
  logic copy;
  logic tmr_exp;
  logic tmo_set;

  assign cyc     = acnt + (phase ? REV_LEN : '0);
  assign lock    = hwag_start & ch_ena;
  assign wrap    = hwag_start & (cyc < prev_cyc);
  assign cfg_ok  = (cfg_set <= CYC_MAX)
                 & (cfg_reset <= CYC_MAX)
                 & (cfg_set != cfg_reset);
  assign copy    = pending & ((state == IDLE) | wrap);
  assign tmr_exp = (cfg_max_on != '0) & (timer >= cfg_max_on);
  assign busy    = (state == ON);

  hwag_arc_cross u_set (
    .prev   (prev_cyc),
    .cur    (cyc),
    .target (act_set),
    .hit    (set_hit)
  );

  hwag_arc_cross u_reset (
    .prev   (prev_cyc),
    .cur    (cyc),
    .target (act_reset),
    .hit    (reset_hit)
  );

  // Reset wins over set; a set and reset in one step never opens a pulse.
  always_comb begin
    state_n = state;
    tmo_set = 1'b0;
    case (state)
      IDLE: begin
        if (lock) state_n = ARMED;
      end
      ARMED: begin
        if (!lock)
          state_n = IDLE;
        else if (set_hit && !reset_hit)
          state_n = ON;
      end
      ON: begin
        if (!lock) begin
          state_n = IDLE;
        end else if (reset_hit) begin
          state_n = ARMED;
        end else if (tmr_exp) begin
          state_n = ARMED;
          tmo_set = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      out      <= 1'b0;
      prev_cyc <= '0;
      timer    <= '0;
    end else begin
      state <= state_n;
      out   <= (state_n == ON);
      if (hwag_start)
        prev_cyc <= cyc;
      if ((state_n == ON) && (state != ON))
        timer <= '0;
      else if ((state == ON) && (timer != '1))
        timer <= timer + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_set    <= '0;
      sh_reset  <= '0;
      act_set   <= '0;
      act_reset <= '0;
      pending   <= 1'b0;
      cfg_err   <= 1'b0;
      tmo       <= 1'b0;
    end else begin
      if (copy) begin
        act_set   <= sh_set;
        act_reset <= sh_reset;
      end
      if (cfg_wr && cfg_ok) begin
        sh_set   <= cfg_set;
        sh_reset <= cfg_reset;
        pending  <= 1'b1;
      end else if (copy) begin
        pending <= 1'b0;
      end
      if (cfg_wr)
        cfg_err <= !cfg_ok;
      if (tmo_set)
        tmo <= 1'b1;
      else if (cfg_wr)
        tmo <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hwag_ign_channel.sv
// Directed bench for hwag_ign_channel with an expectation queue
// drained after every clock edge.
module tb_hwag_ign_channel;

  localparam int AW = 24;
  localparam int TW = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic          hwag_start;
  logic [AW-1:0] acnt;
  logic          phase;
  logic [AW-1:0] cfg_set;
  logic [AW-1:0] cfg_reset;
  logic [TW-1:0] cfg_max_on;
  logic          cfg_wr;
  logic          ch_ena;
  logic          out;
  logic          busy;
  logic          tmo;
  logic          cfg_err;

  hwag_ign_channel dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .acnt       (acnt),
    .phase      (phase),
    .cfg_set    (cfg_set),
    .cfg_reset  (cfg_reset),
    .cfg_max_on (cfg_max_on),
    .cfg_wr     (cfg_wr),
    .ch_ena     (ch_ena),
    .out        (out),
    .busy       (busy),
    .tmo        (tmo),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  localparam int S_OUT  = 0;
  localparam int S_BUSY = 1;
  localparam int S_TMO  = 2;
  localparam int S_ERR  = 3;

  typedef struct {
    string tag;
    int    sig;
    logic  exp;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  function automatic logic obs(input int s);
    logic v;
    v = 1'bx;
    case (s)
      S_OUT:  v = out;
      S_BUSY: v = busy;
      S_TMO:  v = tmo;
      S_ERR:  v = cfg_err;
      default: v = 1'bx;
    endcase
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] o,
                       input logic [31:0] e);
    n_chk++;
    assert (o === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, o, e);
    end
  endtask

  task automatic push(input string tag, input int s, input logic v);
    exp_t e;
    e.tag = tag;
    e.sig = s;
    e.exp = v;
    sbq.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      check(e.tag, {31'd0, obs(e.sig)}, {31'd0, e.exp});
    end
  endtask

  task automatic set_cyc(input int c);
    acnt  = AW'(c % 3840);
    phase = (c >= 3840);
  endtask

  task automatic step(input int c, input logic eo, input string tag);
    set_cyc(c);
    push(tag, S_OUT, eo);
    tick();
  endtask

  task automatic wr_step(input int c, input int s, input int r,
                         input int m, input logic eo,
                         input logic eerr, input string tag);
    cfg_set    = AW'(s);
    cfg_reset  = AW'(r);
    cfg_max_on = TW'(m);
    cfg_wr     = 1'b1;
    push({tag, "_err"}, S_ERR, eerr);
    step(c, eo, tag);
    cfg_wr = 1'b0;
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst        = 1'b1;
    hwag_start = 1'b0;
    ch_ena     = 1'b0;
    acnt       = '0;
    phase      = 1'b0;
    cfg_set    = '0;
    cfg_reset  = '0;
    cfg_max_on = '0;
    cfg_wr     = 1'b0;
    tick();
    push("rst_out", S_OUT, 1'b0);
    push("rst_busy", S_BUSY, 1'b0);
    push("rst_tmo", S_TMO, 1'b0);
    push("rst_err", S_ERR, 1'b0);
    tick();
    rst = 1'b0;

    // Basic pulse over a full 720-degree cycle, stepping by one.
    wr_step(0, 100, 228, 0, 1'b0, 1'b0, "cfg1");
    step(0, 1'b0, "copy1");
    hwag_start = 1'b1;
    ch_ena     = 1'b1;
    push("entry_busy", S_BUSY, 1'b0);
    step(0, 1'b0, "entry");
    for (int c = 1; c < 7680; c++)
      step(c, (c >= 100 && c < 228), $sformatf("t1 c=%0d", c));
    step(0, 1'b0, "t1_wrap");

    // Mid-cycle write waits for the wrap, then a pulse across the wrap.
    wr_step(0, 7600, 64, 0, 1'b0, 1'b0, "cfg2");
    for (int c = 1; c < 7680; c++)
      step(c, (c >= 100 && c < 228), $sformatf("t2a c=%0d", c));
    for (int c = 1; c < 7680; c++)
      step(c, (c >= 7600), $sformatf("t2b c=%0d", c));
    for (int c = 0; c <= 100; c++)
      step(c, (c < 64), $sformatf("t2c c=%0d", c));

    // Out-of-range write is rejected; active stays 7600/64.
    wr_step(101, 8000, 64, 0, 1'b0, 1'b1, "bad_wr");
    step(7590, 1'b0, "j7590");
    step(7610, 1'b1, "j7610");
    step(7679, 1'b1, "j7679");
    step(0, 1'b1, "jwrap");
    step(30, 1'b1, "j30");
    step(70, 1'b0, "j70");
    step(7590, 1'b0, "k7590");
    push("err_sticky", S_ERR, 1'b1);
    step(7610, 1'b1, "k7610");
    wr_step(7620, 100, 228, 0, 1'b1, 1'b0, "good_wr");
    step(7679, 1'b1, "m7679");
    step(0, 1'b1, "mwrap");
    step(50, 1'b1, "m50");
    push("both_on_busy", S_BUSY, 1'b0);
    step(240, 1'b0, "both_on");
    step(90, 1'b0, "r90");
    step(130, 1'b1, "resync_set");
    step(240, 1'b0, "r240");

    // Set and reset both inside one jump while armed.
    wr_step(250, 100, 110, 0, 1'b0, 1'b0, "cfg3");
    step(50, 1'b0, "s50");
    step(90, 1'b0, "s90");
    push("both_arm_busy", S_BUSY, 1'b0);
    step(130, 1'b0, "both_arm");

    // Max-on guard.
    wr_step(140, 100, 228, 50, 1'b0, 1'b0, "cfg4");
    step(50, 1'b0, "u50");
    step(90, 1'b0, "u90");
    step(130, 1'b1, "u130");
    cnt = 1;
    for (int i = 0; i < 200 && out; i++) begin
      tick();
      if (out) cnt++;
    end
    check("on_cycles", cnt, 51);
    check("tmo_set", {31'd0, tmo}, 1);
    check("tmo_busy", {31'd0, busy}, 0);
    step(3000, 1'b0, "v3000");
    step(50, 1'b0, "v50");
    step(90, 1'b0, "v90");
    push("tmo_keep", S_TMO, 1'b1);
    step(130, 1'b1, "rearm");
    step(130, 1'b1, "hold");

    // Loss of sync mid-pulse, then re-lock behind the set angle.
    hwag_start = 1'b0;
    push("unlock_busy", S_BUSY, 1'b0);
    step(130, 1'b0, "unlock");
    hwag_start = 1'b1;
    push("relock_busy", S_BUSY, 1'b0);
    step(110, 1'b0, "relock");
    step(120, 1'b0, "relock2");
    push("tmo_clr", S_TMO, 1'b0);
    wr_step(125, 100, 228, 0, 1'b0, 1'b0, "cfg5");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
